// File: rtl/sys_write_buffer.sv
// ---------------------------------------------------------------------------
// sys_write_buffer
//
// Posted-write buffer between the cache controller's system-side port and
// system memory. Writes are queued in a small FIFO and acknowledged right
// away, so write-through traffic does not wait on memory. Reads bypass the
// FIFO, but they are only issued once the FIFO has fully drained. This keeps
// memory ordering strict. A single memory port serves both the drain engine
// and reads.
//
// Handshakes:
//   System side: S_strobe is a one-cycle request pulse. S_rw, S_addr and
//   S_wdata are sampled with it. Every accepted request produces exactly one
//   one-cycle S_ready pulse. A strobe that arrives while a request is still
//   outstanding is dropped and sets the sticky Proto_err flag.
//   Memory side: M_req is raised with M_we/M_addr/M_wdata and all of them
//   stay constant until the single-cycle M_ack. M_ack is ignored while
//   M_req=0. M_req drops in the cycle after M_ack, so there is always at
//   least one idle cycle between memory transactions.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   S_strobe/S_rw/S_addr/S_wdata   request from cache controller
//   S_rdata, S_ready         read data (held until next read) / completion
//   M_req/M_we/M_addr/M_wdata      memory request
//   M_rdata, M_ack           memory response
//   Full, Empty, Count       FIFO occupancy
//   Proto_err                sticky protocol violation flag
//   dbg_state                {drain_state, request_state} for observation
// ---------------------------------------------------------------------------
module sys_write_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     S_strobe,
  input  logic                     S_rw,
  input  logic [ADDR_W-1:0]        S_addr,
  input  logic [DATA_W-1:0]        S_wdata,
  output logic [DATA_W-1:0]        S_rdata,
  output logic                     S_ready,
  output logic                     M_req,
  output logic                     M_we,
  output logic [ADDR_W-1:0]        M_addr,
  output logic [DATA_W-1:0]        M_wdata,
  input  logic [DATA_W-1:0]        M_rdata,
  input  logic                     M_ack,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Proto_err,
  output logic [2:0]               dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_WPEND  = 2'd1,
    R_RDRAIN = 2'd2,
    R_RMEM   = 2'd3
  } req_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } drain_state_t;

  req_state_t   r_state;
  drain_state_t d_state;

  // FIFO storage and pointers. Pointers are PW bits wide, so they wrap modulo
  // DEPTH without any extra logic because DEPTH is a power of two.
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // A request that is waiting in WPEND or RDRAIN is held here.
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic              pop;
  logic              slot_free;
  logic              want_push;
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [CW-1:0]     push_ext;
  logic [CW-1:0]     pop_ext;

  assign Full      = (Count == CW'(DEPTH));
  assign Empty     = (Count == '0);
  assign dbg_state = {d_state, r_state};

  // A pop frees a slot at the same edge, so a write that arrives while the
  // FIFO is full can still be enqueued on the edge where the head retires.
  always_comb begin
    pop       = 1'b0;
    slot_free = 1'b0;
    want_push = 1'b0;
    push      = 1'b0;
    push_addr = S_addr;
    push_data = S_wdata;

    pop       = (d_state == D_BUSY) && M_ack;
    slot_free = !Full || pop;
    want_push = ((r_state == R_IDLE) && S_strobe && !S_rw) ||
                (r_state == R_WPEND);
    push      = want_push && slot_free;

    if (r_state == R_WPEND) begin
      push_addr = lat_addr;
      push_data = lat_data;
    end
  end

  assign push_ext = {{(CW-1){1'b0}}, push};
  assign pop_ext  = {{(CW-1){1'b0}}, pop};

  // The storage array has no reset. Only entries that lie between the
  // pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
    end
  end

  // Both FSMs share one block because they share the memory port registers.
  // Their memory-port actions are mutually exclusive:
  //   - a read is issued only when the FIFO is empty and drain is idle;
  //   - drain starts only when the FIFO is non-empty and no read is in memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      d_state   <= D_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      Count     <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      S_rdata   <= '0;
      S_ready   <= 1'b0;
      M_req     <= 1'b0;
      M_we      <= 1'b0;
      M_addr    <= '0;
      M_wdata   <= '0;
      Proto_err <= 1'b0;
    end else begin
      S_ready <= 1'b0;

      // Only one request may be outstanding at a time.
      if (S_strobe && (r_state != R_IDLE)) begin
        Proto_err <= 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      Count <= Count + push_ext - pop_ext;

      // ---------------- request FSM ----------------
      case (r_state)
        R_IDLE: begin
          if (S_strobe) begin
            if (S_rw) begin
              lat_addr <= S_addr;
              r_state  <= R_RDRAIN;
            end else if (push) begin
              S_ready <= 1'b1;
            end else begin
              lat_addr <= S_addr;
              lat_data <= S_wdata;
              r_state  <= R_WPEND;
            end
          end
        end

        R_WPEND: begin
          if (push) begin
            S_ready <= 1'b1;
            r_state <= R_IDLE;
          end
        end

        R_RDRAIN: begin
          if (Empty && (d_state == D_IDLE)) begin
            M_req   <= 1'b1;
            M_we    <= 1'b0;
            M_addr  <= lat_addr;
            r_state <= R_RMEM;
          end
        end

        R_RMEM: begin
          if (M_ack) begin
            S_rdata <= M_rdata;
            S_ready <= 1'b1;
            M_req   <= 1'b0;
            r_state <= R_IDLE;
          end
        end

        default: r_state <= R_IDLE;
      endcase

      // ---------------- drain engine ----------------
      // Count is the registered value, so an entry written at edge E is first
      // seen here at edge E+1. That gives the one-cycle hand-off to M_req.
      case (d_state)
        D_IDLE: begin
          if (!Empty && (r_state != R_RMEM)) begin
            M_req   <= 1'b1;
            M_we    <= 1'b1;
            M_addr  <= fifo_addr[rd_ptr];
            M_wdata <= fifo_data[rd_ptr];
            d_state <= D_BUSY;
          end
        end

        D_BUSY: begin
          if (M_ack) begin
            M_req   <= 1'b0;
            d_state <= D_IDLE;
          end
        end

        default: d_state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_sys_write_buffer
//
// Self-checking bench for sys_write_buffer (DEPTH=4, 32-bit address/data).
// A memory responder acknowledges requests after a programmable delay. Each
// memory transaction it sees is compared against an expected queue, which
// the driver fills as it issues requests. A vector table then exercises
// mixed writes and reads. Hand-written sequences cover reset, latency,
// full/stall, protocol error and reset-mid-operation.
// ---------------------------------------------------------------------------
module tb_sys_write_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int EW    = 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          S_strobe = 1'b0;
  logic          S_rw     = 1'b0;
  logic [AW-1:0] S_addr   = '0;
  logic [DW-1:0] S_wdata  = '0;
  logic [DW-1:0] S_rdata;
  logic          S_ready;
  logic          M_req;
  logic          M_we;
  logic [AW-1:0] M_addr;
  logic [DW-1:0] M_wdata;
  logic [DW-1:0] M_rdata  = '0;
  logic          M_ack    = 1'b0;
  logic          Full;
  logic          Empty;
  logic [CW-1:0] Count;
  logic          Proto_err;
  logic [2:0]    dbg_state;

  sys_write_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .S_strobe  (S_strobe),
    .S_rw      (S_rw),
    .S_addr    (S_addr),
    .S_wdata   (S_wdata),
    .S_rdata   (S_rdata),
    .S_ready   (S_ready),
    .M_req     (M_req),
    .M_we      (M_we),
    .M_addr    (M_addr),
    .M_wdata   (M_wdata),
    .M_rdata   (M_rdata),
    .M_ack     (M_ack),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Proto_err (Proto_err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int             n_vec  = 0;
  int             n_miss = 0;
  logic [EW-1:0]  exp_q[$];

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_q.push_back({we, a, d});
  endtask

  // ---------------- memory responder ----------------
  int            ack_delay     = 1;
  bit            ack_en        = 1'b1;
  logic [DW-1:0] mem_rdata_val = '0;
  bit            in_txn        = 1'b0;
  int            mcnt          = 0;
  logic [EW-1:0] cap;
  logic [EW-1:0] e;

  always @(posedge clk) begin
    #1;
    M_ack   = 1'b0;
    M_rdata = $urandom;
    if (rst || !M_req) begin
      in_txn = 1'b0;
      mcnt   = 0;
    end else begin
      if (!in_txn) begin
        in_txn = 1'b1;
        mcnt   = 0;
        cap    = {M_we, M_addr, M_wdata};
      end
      if (ack_en) begin
        if (mcnt >= ack_delay) begin
          M_ack   = 1'b1;
          M_rdata = mem_rdata_val;
          check("mem_stable", {M_we, M_addr, M_wdata}, cap);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL mem_unexpected: got we=%0b addr=%0h, want no transaction",
                     M_we, M_addr);
          end else begin
            e = exp_q.pop_front();
            check("mem_we", EW'(M_we), EW'(e[EW-1]));
            check("mem_addr", EW'(M_addr), EW'(e[AW+DW-1:DW]));
            if (e[EW-1]) check("mem_wdata", EW'(M_wdata), EW'(e[DW-1:0]));
          end
          in_txn = 1'b0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  // Activity monitor used after a mid-operation reset.
  bit mon_en    = 1'b0;
  bit saw_req   = 1'b0;
  bit saw_ready = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (M_req)   saw_req   = 1'b1;
      if (S_ready) saw_ready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    S_strobe = 1'b1;
    S_rw     = rw;
    S_addr   = a;
    S_wdata  = d;
    tick();
    S_strobe = 1'b0;
  endtask

  task automatic wait_ready(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      if (S_ready) break;
      tick();
    end
    check(name, EW'(S_ready), EW'(1));
  endtask

  task automatic wait_drained(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      if (Empty && !M_req && exp_q.size() == 0) break;
      tick();
    end
    check({name, "_empty"}, EW'(Empty), EW'(1));
    check({name, "_q"}, EW'(exp_q.size()), EW'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_S_ready"},   EW'(S_ready),   EW'(0));
    check({tag, "_M_req"},     EW'(M_req),     EW'(0));
    check({tag, "_M_we"},      EW'(M_we),      EW'(0));
    check({tag, "_M_addr"},    EW'(M_addr),    EW'(0));
    check({tag, "_M_wdata"},   EW'(M_wdata),   EW'(0));
    check({tag, "_S_rdata"},   EW'(S_rdata),   EW'(0));
    check({tag, "_Count"},     EW'(Count),     EW'(0));
    check({tag, "_Empty"},     EW'(Empty),     EW'(1));
    check({tag, "_Full"},      EW'(Full),      EW'(0));
    check({tag, "_Proto_err"}, EW'(Proto_err), EW'(0));
    check({tag, "_dbg_state"}, EW'(dbg_state), EW'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] r;

    // Reset with random inputs applied.
    S_strobe = 1'($urandom_range(0, 1));
    S_rw     = 1'($urandom_range(0, 1));
    S_addr   = $urandom;
    S_wdata  = $urandom;
    #2;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    S_strobe = 1'b0;
    rst      = 1'b0;
    tick();

    // Single write: check latency and the memory hand-off timing.
    ack_en    = 1'b1;
    ack_delay = 3;
    push_exp(1'b1, 32'h10, 32'hA5A5A5A5);
    drive(1'b0, 32'h10, 32'hA5A5A5A5);
    check("wr1_ready",     EW'(S_ready), EW'(1));
    check("wr1_no_req_t1", EW'(M_req),   EW'(0));
    check("wr1_count",     EW'(Count),   EW'(1));
    tick();
    check("wr1_ready_once", EW'(S_ready), EW'(0));
    check("wr1_req_t2",     EW'(M_req),   EW'(1));
    check("wr1_we",         EW'(M_we),    EW'(1));
    check("wr1_addr",       EW'(M_addr),  EW'(32'h10));
    check("wr1_wdata",      EW'(M_wdata), EW'(32'hA5A5A5A5));
    repeat (3) tick();
    check("wr1_req_held", EW'(M_req), EW'(1));
    tick();
    check("wr1_req_drop", EW'(M_req), EW'(0));
    check("wr1_empty",    EW'(Empty), EW'(1));
    check("wr1_count0",   EW'(Count), EW'(0));

    // Fill the FIFO while memory is stalled, then stall a fifth write.
    ack_en    = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b1, AW'(i * 4), DW'(32'hF000 + i));
      drive(1'b0, AW'(i * 4), DW'(32'hF000 + i));
      check("fill_ready", EW'(S_ready), EW'(1));
    end
    check("fill_full",  EW'(Full),  EW'(1));
    check("fill_count", EW'(Count), EW'(4));
    push_exp(1'b1, 32'h10, 32'hF004);
    drive(1'b0, 32'h10, 32'hF004);
    check("stall_no_ready", EW'(S_ready), EW'(0));
    repeat (2) tick();
    check("stall_no_ready2", EW'(S_ready),        EW'(0));
    check("stall_wpend",     EW'(dbg_state[1:0]), EW'(1));
    check("stall_count",     EW'(Count),          EW'(4));
    @(negedge clk);
    ack_en = 1'b1;
    tick();
    check("swap_no_ready_yet", EW'(S_ready), EW'(0));
    tick();
    check("swap_ready", EW'(S_ready), EW'(1));
    check("swap_count", EW'(Count),   EW'(4));
    wait_drained(80, "fill_drain");

    // Table of mixed writes and reads.
    ack_delay = 1;
    vecs[0] = '{1'b0, 32'h20, 32'h11112222, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 32'h24, 32'h33334444, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 32'h20, 32'h0, 32'h12345678, 32'h12345678};
    vecs[3] = '{1'b0, 32'h30, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[4] = '{1'b0, 32'h34, 32'h01020304, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 32'h34, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 32'h40, 32'h0, 32'h0BADF00D, 32'h0BADF00D};
    for (int i = 7; i < NV; i++) begin
      r = $urandom;
      vecs[i].rw        = ($urandom_range(0, 2) == 0);
      vecs[i].addr      = {$urandom} & 32'hFFFC;
      vecs[i].wdata     = $urandom;
      vecs[i].mem_rdata = r;
      vecs[i].exp_rdata = r;
    end
    last_rdata = '0;
    for (int i = 0; i < NV; i++) begin
      mem_rdata_val = vecs[i].mem_rdata;
      push_exp(!vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      drive(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].rw) begin
        check("vec_wr_ready",   EW'(S_ready), EW'(1));
        check("vec_rdata_hold", EW'(S_rdata), EW'(last_rdata));
        repeat (3) tick();
      end else begin
        check("vec_rd_not_early", EW'(S_ready), EW'(0));
        wait_ready(100, "vec_rd_ready");
        check("vec_rd_data", EW'(S_rdata), EW'(vecs[i].exp_rdata));
        last_rdata = vecs[i].exp_rdata;
        tick();
        check("vec_rd_single", EW'(S_ready), EW'(0));
      end
    end
    wait_drained(80, "vec_drain");

    // A second strobe during RDRAIN is dropped and sets the sticky error.
    ack_delay = 3;
    check("proto_clear", EW'(Proto_err), EW'(0));
    push_exp(1'b1, 32'h60, 32'h66666666);
    drive(1'b0, 32'h60, 32'h66666666);
    check("proto_wr_ready", EW'(S_ready), EW'(1));
    mem_rdata_val = 32'h55AA55AA;
    push_exp(1'b0, 32'h50, 32'h0);
    drive(1'b1, 32'h50, 32'h0);
    check("proto_rdrain", EW'(dbg_state[1:0]), EW'(2));
    drive(1'b0, 32'h70, 32'h77777777);
    check("proto_set",      EW'(Proto_err), EW'(1));
    check("proto_no_ready", EW'(S_ready),   EW'(0));
    wait_ready(100, "proto_rd_ready");
    check("proto_rd_data", EW'(S_rdata), EW'(32'h55AA55AA));
    tick();
    check("proto_rd_single", EW'(S_ready), EW'(0));
    repeat (5) tick();
    check("proto_sticky", EW'(Proto_err), EW'(1));
    wait_drained(40, "proto_drain");

    // Reset in the middle of a memory acknowledge with writes queued.
    ack_delay = 2;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, AW'(32'h80 + i * 4), DW'(32'hB000 + i));
      drive(1'b0, AW'(32'h80 + i * 4), DW'(32'hB000 + i));
      check("rstmid_wr_ready", EW'(S_ready), EW'(1));
    end
    for (int i = 0; i < 50; i++) begin
      if (M_ack) break;
      tick();
    end
    check("rstmid_ack_seen", EW'(M_ack), EW'(1));
    @(negedge clk);
    rst      = 1'b1;
    S_strobe = 1'($urandom_range(0, 1));
    S_rw     = 1'($urandom_range(0, 1));
    S_addr   = $urandom;
    S_wdata  = $urandom;
    #1;
    check_reset_values("rstmid");
    exp_q.delete();
    @(negedge clk);
    S_strobe = 1'b0;
    rst      = 1'b0;
    mon_en   = 1'b1;
    repeat (30) tick();
    mon_en = 1'b0;
    check("rstmid_no_req",   EW'(saw_req),   EW'(0));
    check("rstmid_no_ready", EW'(saw_ready), EW'(0));
    check("rstmid_count",    EW'(Count),     EW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    n_vec++;
    n_miss++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
